display_scan_controller: RTL and testbench

- Sequences the seven-segment display datapath from the latched 16-bit value and the hex/decimal mode flag.
- Owns three jobs: binary-to-BCD conversion, leading-zero blanking, and time-multiplexed anode scanning.
- Decimal values are converted by a sequential double-dabble engine. The FSM guarantees that the digits shown always come from one coherent value/mode snapshot.

---
 rtl/display_scan_controller.sv | 183 ++++++++++++++++++
 tb/tb_display_scan_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Seven-segment scan controller: snapshots value/mode, converts decimal with a
// sequential double-dabble, blanks leading zeros and multiplexes five digits.
module display_scan_controller #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned REFRESH_HZ = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        display_is_hex,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        conv_busy
);

  localparam int unsigned TICK_PERIOD = CLK_FREQ / REFRESH_HZ;
  localparam int unsigned TICK_W      = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;
  localparam int unsigned VAL_W       = 16;
  localparam int unsigned BCD_W       = 20;
  localparam int unsigned SCNT_W      = 5;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned NUM_DIGITS  = 5;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t              state_q, state_d;
  logic [VAL_W-1:0]    snap_value;
  logic                snap_hex;
  logic                snap_valid;
  logic [VAL_W-1:0]    bin_q;
  logic [BCD_W-1:0]    bcd_q;
  logic [SCNT_W-1:0]   shift_cnt;
  logic [3:0]          digit_q [NUM_DIGITS];
  logic                mode_hex_q;
  logic [TICK_W-1:0]   tick_cnt;
  logic [IDX_W-1:0]    scan_idx;

  logic                snap_load_c, start_dec_c, commit_c;
  logic [BCD_W-1:0]    bcd_adj_c;
  logic [NUM_DIGITS-1:0] blank_c;
  logic                lead_zero_c;
  logic [3:0]          cur_digit_c;

  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    case (d)
      4'h0: seg_glyph = 7'b1000000;
      4'h1: seg_glyph = 7'b1111001;
      4'h2: seg_glyph = 7'b0100100;
      4'h3: seg_glyph = 7'b0110000;
      4'h4: seg_glyph = 7'b0011001;
      4'h5: seg_glyph = 7'b0010010;
      4'h6: seg_glyph = 7'b0000010;
      4'h7: seg_glyph = 7'b1111000;
      4'h8: seg_glyph = 7'b0000000;
      4'h9: seg_glyph = 7'b0010000;
      4'hA: seg_glyph = 7'b0001000;
      4'hB: seg_glyph = 7'b0000011;
      4'hC: seg_glyph = 7'b1000110;
      4'hD: seg_glyph = 7'b0100001;
      4'hE: seg_glyph = 7'b0000110;
      default: seg_glyph = 7'b0001110;
    endcase
  endfunction

  // State register; busy mirrors the next state so it is high exactly while not IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      conv_busy <= 1'b0;
    end else begin
      state_q   <= state_d;
      conv_busy <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d     = state_q;
    snap_load_c = 1'b0;
    start_dec_c = 1'b0;
    commit_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!snap_valid || ({display_is_hex, value} != {snap_hex, snap_value})) begin
          snap_load_c = 1'b1;
          if (display_is_hex) begin
            state_d = COMMIT;
          end else begin
            start_dec_c = 1'b1;
            state_d     = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (shift_cnt == SCNT_W'(VAL_W - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        commit_c = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Double-dabble correction: add 3 to every BCD nibble >= 5 before shifting
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_value <= '0;
      snap_hex   <= 1'b0;
      snap_valid <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      shift_cnt  <= '0;
      mode_hex_q <= 1'b0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) digit_q[i] <= 4'h0;
    end else begin
      if (snap_load_c) begin
        snap_value <= value;
        snap_hex   <= display_is_hex;
        snap_valid <= 1'b1;
      end
      if (start_dec_c) begin
        bin_q     <= value;
        bcd_q     <= '0;
        shift_cnt <= '0;
      end else if (state_q == SHIFT) begin
        {bcd_q, bin_q} <= {bcd_adj_c, bin_q} << 1;
        shift_cnt      <= shift_cnt + SCNT_W'(1);
      end
      // Digits and mode change together so blanking always sees a coherent pair
      if (commit_c) begin
        mode_hex_q <= snap_hex;
        if (snap_hex) begin
          for (int i = 0; i < 4; i++) digit_q[i] <= snap_value[4*i +: 4];
          digit_q[4] <= 4'h0;
        end else begin
          for (int i = 0; i < int'(NUM_DIGITS); i++) digit_q[i] <= bcd_q[4*i +: 4];
        end
      end
    end
  end

  // Leading-zero blanking in decimal; hex always blanks only the fifth digit
  always_comb begin
    lead_zero_c = 1'b1;
    blank_c     = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      lead_zero_c = lead_zero_c & (digit_q[i] == 4'h0);
      blank_c[i]  = (i != 0) && lead_zero_c;
    end
    if (mode_hex_q) blank_c = 5'b10000;
  end

  assign cur_digit_c = digit_q[scan_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      scan_idx <= '0;
      an       <= 8'hFF;
      seg      <= 7'h7F;
    end else begin
      if (tick_cnt == TICK_W'(TICK_PERIOD - 1)) begin
        tick_cnt <= '0;
        scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
      an  <= ~(8'(1) << scan_idx);
      seg <= blank_c[scan_idx] ? 7'h7F : seg_glyph(cur_digit_c);
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: latency/arithmetic reference model checked
// every cycle, plus literal per-slot glyph, busy-length and scan-period checks.
module tb_display_scan_controller;

  localparam int unsigned CLK_FREQ   = 1000;
  localparam int unsigned REFRESH_HZ = 100;
  localparam int          PERIOD     = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0;
  logic        display_is_hex = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        conv_busy;

  int checks = 0;
  int errors = 0;

  display_scan_controller #(.CLK_FREQ(CLK_FREQ), .REFRESH_HZ(REFRESH_HZ)) dut (
    .clk(clk), .reset(reset), .value(value), .display_is_hex(display_is_hex),
    .an(an), .seg(seg), .dp(dp), .conv_busy(conv_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hexglyph(int d);
    case (d)
      0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;
      3: return 7'b0110000;   4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;   8: return 7'b0000000;
      9: return 7'b0010000;  10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001;  14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Glyph the display must show on slot idx for a committed value/mode
  function automatic logic [6:0] model_seg(int idx, int val, bit hex);
    int pw;
    pw = 1;
    if (hex) return (idx == 4) ? 7'h7F : hexglyph((val >> (4 * idx)) & 15);
    for (int i = 0; i < idx; i++) pw = pw * 10;
    if (idx > 0 && val < pw) return 7'h7F;
    return hexglyph((val / pw) % 10);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: conversion is a latency (17 decimal / 1 hex) after a change seen while idle
  logic [7:0]  m_an = 8'hFF;
  logic [6:0]  m_seg = 7'h7F;
  logic        m_busy = 1'b0;
  int          m_left = 0;
  logic        m_sv = 1'b0;
  logic [15:0] m_sval = 16'h0;
  logic        m_shex = 1'b0;
  logic [15:0] m_dval = 16'h0;
  logic        m_dhex = 1'b0;
  int          m_tick = 0;
  int          m_idx = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_an <= 8'hFF; m_seg <= 7'h7F; m_busy <= 1'b0; m_left <= 0;
      m_sv <= 1'b0; m_sval <= 16'h0; m_shex <= 1'b0;
      m_dval <= 16'h0; m_dhex <= 1'b0; m_tick <= 0; m_idx <= 0;
    end else begin : model_step
      int left_n;
      left_n = m_left;
      m_an  <= 8'hFF & ~(8'(1) << m_idx);
      m_seg <= model_seg(m_idx, int'(m_dval), m_dhex);
      if (left_n > 0) begin
        left_n = left_n - 1;
        if (left_n == 0) begin
          m_dval <= m_sval;
          m_dhex <= m_shex;
        end
      end else if (!m_sv || m_sval !== value || m_shex !== display_is_hex) begin
        m_sv   <= 1'b1;
        m_sval <= value;
        m_shex <= display_is_hex;
        left_n = display_is_hex ? 1 : 17;
      end
      m_left <= left_n;
      m_busy <= (left_n > 0);
      if (m_tick == PERIOD - 1) begin
        m_tick <= 0;
        m_idx  <= (m_idx + 1) % 5;
      end else begin
        m_tick <= m_tick + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("an", 32'(an), 32'(m_an));
    check("seg", 32'(seg), 32'(m_seg));
    check("dp", 32'(dp), 32'd1);
    check("conv_busy", 32'(conv_busy), 32'(m_busy));
  end

  task automatic set_inputs(logic [15:0] v, logic h);
    @(posedge clk);
    #1;
    value = v;
    display_is_hex = h;
  endtask

  task automatic count_busy(int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (conv_busy) cnt++;
    end
  endtask

  task automatic wait_an(logic [7:0] pat, output bit ok);
    int k;
    k = 0;
    @(negedge clk);
    while (an !== pat && k < 80) begin
      @(negedge clk);
      k++;
    end
    ok = (an === pat);
  endtask

  task automatic check_slot(string name, logic [7:0] pat, logic [6:0] exp);
    bit ok;
    wait_an(pat, ok);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for an=%0h (got %0h)", name, pat, an);
    end else begin
      check(name, 32'(seg), 32'(exp));
    end
  endtask

  initial begin
    int cnt;
    bit ok;
    logic [7:0] an_seq [5];
    logic [7:0] prev;
    an_seq[0] = 8'hFD; an_seq[1] = 8'hFB; an_seq[2] = 8'hF7;
    an_seq[3] = 8'hEF; an_seq[4] = 8'hFE;

    // Reset state and power-on conversion of 0
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", 32'(an), 32'hFF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_busy", 32'(conv_busy), 32'd0);
    reset = 1'b0;
    count_busy(25, cnt);
    check("busy_len_dec0", 32'(cnt), 32'd17);
    check_slot("zero_d0", 8'hFE, 7'b1000000);
    check_slot("zero_d1", 8'hFD, 7'h7F);
    check_slot("zero_d2", 8'hFB, 7'h7F);
    check_slot("zero_d3", 8'hF7, 7'h7F);
    check_slot("zero_d4", 8'hEF, 7'h7F);

    // Decimal maximum 65535
    set_inputs(16'hFFFF, 1'b0);
    count_busy(25, cnt);
    check("busy_len_ffff", 32'(cnt), 32'd17);
    check_slot("max_d0", 8'hFE, 7'b0010010);
    check_slot("max_d1", 8'hFD, 7'b0110000);
    check_slot("max_d2", 8'hFB, 7'b0010010);
    check_slot("max_d3", 8'hF7, 7'b0010010);
    check_slot("max_d4", 8'hEF, 7'b0000010);

    // Hex BEEF: one-cycle commit, digit 4 blank
    set_inputs(16'hBEEF, 1'b1);
    count_busy(5, cnt);
    check("busy_len_hex", 32'(cnt), 32'd1);
    check_slot("hex_d0", 8'hFE, 7'b0001110);
    check_slot("hex_d1", 8'hFD, 7'b0000110);
    check_slot("hex_d2", 8'hFB, 7'b0000110);
    check_slot("hex_d3", 8'hF7, 7'b0000011);
    check_slot("hex_d4", 8'hEF, 7'h7F);

    // Hex zero keeps all four zeros
    set_inputs(16'h0000, 1'b1);
    check_slot("hex0_d3", 8'hF7, 7'b1000000);
    check_slot("hex0_d4", 8'hEF, 7'h7F);
    check_slot("hex0_d0", 8'hFE, 7'b1000000);

    // Decimal 10: blanking boundary
    set_inputs(16'd10, 1'b0);
    repeat (20) @(posedge clk);
    check_slot("ten_d0", 8'hFE, 7'b1000000);
    check_slot("ten_d1", 8'hFD, 7'b1111001);
    check_slot("ten_d2", 8'hFB, 7'h7F);

    // 1234 then 9999 on the 5th SHIFT cycle
    set_inputs(16'd1234, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    value = 16'd9999;
    count_busy(45, cnt);
    check("busy_len_back2back", 32'(cnt), 32'd30);
    check_slot("nines_d0", 8'hFE, 7'b0010000);
    check_slot("nines_d3", 8'hF7, 7'b0010000);
    check_slot("nines_d4", 8'hEF, 7'h7F);

    // Scan cadence: one anode step every PERIOD cycles
    wait_an(8'hEF, ok);
    check("scan_align", 32'(ok), 32'd1);
    while (an === 8'hEF) @(negedge clk);
    check("scan_start", 32'(an), 32'hFE);
    for (int s = 0; s < 5; s++) begin
      prev = an;
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (an === prev && cnt < 20);
      check("scan_period", 32'(cnt), 32'(PERIOD));
      check("scan_an", 32'(an), 32'(an_seq[s]));
    end

    // Asynchronous reset in SHIFT cycle 8 of 54321
    set_inputs(16'd54321, 1'b0);
    repeat (8) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_an", 32'(an), 32'hFF);
    check("async_seg", 32'(seg), 32'h7F);
    check("async_busy", 32'(conv_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    count_busy(25, cnt);
    check("busy_len_after_rst", 32'(cnt), 32'd17);
    check_slot("p_d0", 8'hFE, 7'b1111001);
    check_slot("p_d1", 8'hFD, 7'b0100100);
    check_slot("p_d2", 8'hFB, 7'b0110000);
    check_slot("p_d3", 8'hF7, 7'b0011001);
    check_slot("p_d4", 8'hEF, 7'b0010010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
